exhaustive_vector_checker: RTL and testbench

- Synthesizable successor to the lab's exhaustive truth-table benches.
- Sweeps every input combination 0..2^IN_W-1 onto a combinational DUT and waits a programmable settle time per vector.
- Compares the DUT output against a golden-model output and accumulates a mismatch count.
- Sits between a lab circuit and its golden model; results go to LEDs/logging and replace hand-read $display checking.

---
 rtl/exhaustive_vector_checker_pkg.sv | 20 ++
 rtl/exhaustive_vector_checker_sat_counter.sv | 38 +++
 rtl/exhaustive_vector_checker.sv | 134 +++++++++++++
 tb/tb_exhaustive_vector_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/exhaustive_vector_checker_pkg.sv
// Shared definitions for the exhaustive vector checker.
//   chk_state_e : sweep FSM state encoding (2 bits)
//   SettleW     : width of the per-vector settle counter (covers SETTLE 0..255)
//   vec_count() : number of stimulus vectors for a given input width
package exhaustive_chk_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } chk_state_e;

    localparam int unsigned SettleW = 8;

    function automatic int unsigned vec_count(input int unsigned in_w);
        return 32'd1 << in_w;
    endfunction

endpackage

// File: rtl/exhaustive_vector_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, clears the count
//   clr_i   : synchronous clear (wins over inc_i)
//   inc_i   : increment request; ignored once the count is all-ones
//   count_o : current count
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/exhaustive_vector_checker.sv
// Sweeps every input vector 0..2^IN_W-1 onto a combinational DUT and its golden model,
// waits SETTLE cycles per vector, then compares the two responses for one cycle.
//   clk, reset        : clock and asynchronous active-high reset
//   start             : begin a sweep (honoured only when idle or done)
//   stim              : vector driven to the DUT and golden model
//   dut_out, exp_out  : DUT and golden-model responses to stim
//   busy, done, pass  : sweep status; pass = done with no mismatches
//   err_count         : saturating mismatch count for this sweep
//   first_err_vec/_valid : stim value of the first mismatch
//   smp_valid, smp_match : per-vector compare strobe and result, for logging
module exhaustive_vector_checker #(
    parameter int unsigned IN_W   = 2,
    parameter int unsigned OUT_W  = 1,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] exp_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IN_W-1:0]  first_err_vec,
    output logic             first_err_valid,
    output logic             smp_valid,
    output logic             smp_match
);

    import exhaustive_chk_pkg::*;

    localparam logic [IN_W-1:0]    LastVec    = IN_W'(vec_count(IN_W) - 1);
    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE);
    // With no settle time every vector goes straight to its compare cycle.
    localparam chk_state_e         FirstSt    = (SETTLE == 0) ? StSample : StDrive;

    chk_state_e         state_d, state_q;
    logic [IN_W-1:0]    stim_d, stim_q;
    logic [SettleW-1:0] settle_d, settle_q;
    logic [IN_W-1:0]    first_err_vec_d, first_err_vec_q;
    logic               first_err_valid_d, first_err_valid_q;
    logic               err_clr, err_inc;
    logic               mismatch;

    assign mismatch = (dut_out != exp_out);

    always_comb begin
        state_d           = state_q;
        stim_d            = stim_q;
        settle_d          = settle_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
        err_clr           = 1'b0;
        err_inc           = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d           = FirstSt;
                    stim_d            = '0;
                    settle_d          = SettleLoad;
                    first_err_vec_d   = '0;
                    first_err_valid_d = 1'b0;
                    err_clr           = 1'b1;
                end
            end
            StDrive: begin
                // Counter was loaded with SETTLE, so leaving at 1 gives exactly SETTLE cycles.
                if (settle_q <= SettleW'(1)) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q - SettleW'(1);
                end
            end
            StSample: begin
                if (mismatch) begin
                    err_inc = 1'b1;
                    if (!first_err_valid_q) begin
                        first_err_vec_d   = stim_q;
                        first_err_valid_d = 1'b1;
                    end
                end
                if (stim_q == LastVec) begin
                    state_d = StDone;
                end else begin
                    stim_d   = stim_q + IN_W'(1);
                    settle_d = SettleLoad;
                    state_d  = FirstSt;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= StIdle;
            stim_q            <= '0;
            settle_q          <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            stim_q            <= stim_d;
            settle_q          <= settle_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    sat_counter #(
        .Width (ERR_W)
    ) u_err_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (err_clr),
        .inc_i   (err_inc),
        .count_o (err_count)
    );

    // Status decodes straight from the state flop; smp_match must see this cycle's responses.
    assign stim            = stim_q;
    assign busy            = (state_q == StDrive) || (state_q == StSample);
    assign done            = (state_q == StDone);
    assign pass            = done && (err_count == '0);
    assign first_err_vec   = first_err_vec_q;
    assign first_err_valid = first_err_valid_q;
    assign smp_valid       = (state_q == StSample);
    assign smp_match       = smp_valid && !mismatch;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
module tb_exhaustive_vector_checker;

    logic clk;
    int   n_checks = 0;
    int   n_errors = 0;

    // Instance A: IN_W=2, SETTLE=1, ERR_W=8; DUT optionally wrong at stim==2
    logic       reset_a, start_a, inv_a;
    logic [1:0] stim_a, fev_a;
    logic       dut_a, exp_a, busy_a, done_a, pass_a, fevalid_a, smpv_a, smpm_a;
    logic [7:0] err_a;

    // Instance B: IN_W=3, SETTLE=0, ERR_W=2; DUT always wrong
    logic       reset_b, start_b;
    logic [2:0] stim_b, fev_b;
    logic       dut_b, exp_b, busy_b, done_b, pass_b, fevalid_b, smpv_b, smpm_b;
    logic [1:0] err_b;

    // Instance C: IN_W=2, SETTLE=2, ERR_W=8; DUT optionally wrong at stim==0
    logic       reset_c, start_c, inv_c;
    logic [1:0] stim_c, fev_c;
    logic       dut_c, exp_c, busy_c, done_c, pass_c, fevalid_c, smpv_c, smpm_c;
    logic [7:0] err_c;

    assign exp_a = stim_a[1] ^ stim_a[0];
    assign dut_a = exp_a ^ (inv_a && (stim_a == 2'd2));
    assign exp_b = ^stim_b;
    assign dut_b = ~exp_b;
    assign exp_c = stim_c[1] ^ stim_c[0];
    assign dut_c = exp_c ^ (inv_c && (stim_c == 2'd0));

    exhaustive_vector_checker #(.IN_W(2), .OUT_W(1), .SETTLE(1), .ERR_W(8)) u_dut_a (
        .clk (clk), .reset (reset_a), .start (start_a), .stim (stim_a),
        .dut_out (dut_a), .exp_out (exp_a), .busy (busy_a), .done (done_a), .pass (pass_a),
        .err_count (err_a), .first_err_vec (fev_a), .first_err_valid (fevalid_a),
        .smp_valid (smpv_a), .smp_match (smpm_a)
    );

    exhaustive_vector_checker #(.IN_W(3), .OUT_W(1), .SETTLE(0), .ERR_W(2)) u_dut_b (
        .clk (clk), .reset (reset_b), .start (start_b), .stim (stim_b),
        .dut_out (dut_b), .exp_out (exp_b), .busy (busy_b), .done (done_b), .pass (pass_b),
        .err_count (err_b), .first_err_vec (fev_b), .first_err_valid (fevalid_b),
        .smp_valid (smpv_b), .smp_match (smpm_b)
    );

    exhaustive_vector_checker #(.IN_W(2), .OUT_W(1), .SETTLE(2), .ERR_W(8)) u_dut_c (
        .clk (clk), .reset (reset_c), .start (start_c), .stim (stim_c),
        .dut_out (dut_c), .exp_out (exp_c), .busy (busy_c), .done (done_c), .pass (pass_c),
        .err_count (err_c), .first_err_vec (fev_c), .first_err_valid (fevalid_c),
        .smp_valid (smpv_c), .smp_match (smpm_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         smp_cnt;
        logic [3:0] pat;

        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        inv_a   = 1'b0; inv_c   = 1'b0;
        #2;
        check_eq("rst_stim",    32'(stim_a),    32'd0);
        check_eq("rst_busy",    32'(busy_a),    32'd0);
        check_eq("rst_done",    32'(done_a),    32'd0);
        check_eq("rst_pass",    32'(pass_a),    32'd0);
        check_eq("rst_err",     32'(err_a),     32'd0);
        check_eq("rst_fev",     32'(fev_a),     32'd0);
        check_eq("rst_fevalid", 32'(fevalid_a), 32'd0);
        check_eq("rst_smpv",    32'(smpv_a),    32'd0);
        check_eq("rst_smpm",    32'(smpm_a),    32'd0);
        repeat (2) tick();
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        tick();
        check_eq("idle_busy", 32'(busy_a), 32'd0);

        // Sweep 1: correct DUT, SETTLE=1 -> each vector holds 2 cycles, done at edge 8
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        smp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("a1_stim_e%0d", k), 32'(stim_a), 32'(k / 2));
            check_eq($sformatf("a1_smpv_e%0d", k), 32'(smpv_a), 32'(k % 2));
            check_eq($sformatf("a1_busy_e%0d", k), 32'(busy_a), 32'd1);
            check_eq($sformatf("a1_done_e%0d", k), 32'(done_a), 32'd0);
            if (smpv_a) smp_cnt++;
            tick();
        end
        check_eq("a1_done",    32'(done_a),    32'd1);
        check_eq("a1_busy",    32'(busy_a),    32'd0);
        check_eq("a1_err",     32'(err_a),     32'd0);
        check_eq("a1_pass",    32'(pass_a),    32'd1);
        check_eq("a1_fevalid", 32'(fevalid_a), 32'd0);
        check_eq("a1_smp_cnt", 32'(smp_cnt),   32'd4);

        // Sweep 2: DUT wrong only at stim==2
        inv_a   = 1'b1;
        pat     = 4'b1011;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 1) begin
                check_eq($sformatf("a2_match_v%0d", k / 2), 32'(smpm_a), 32'(pat[k/2]));
            end
            tick();
        end
        check_eq("a2_done",    32'(done_a),    32'd1);
        check_eq("a2_err",     32'(err_a),     32'd1);
        check_eq("a2_fev",     32'(fev_a),     32'd2);
        check_eq("a2_fevalid", 32'(fevalid_a), 32'd1);
        check_eq("a2_pass",    32'(pass_a),    32'd0);
        tick();
        check_eq("a2_hold_err", 32'(err_a), 32'd1);
        check_eq("a2_hold_fev", 32'(fev_a), 32'd2);

        // Sweep 3: restart from a failing DONE with a correct DUT
        inv_a   = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("a3_clr_err",     32'(err_a),     32'd0);
        check_eq("a3_clr_fevalid", 32'(fevalid_a), 32'd0);
        check_eq("a3_clr_fev",     32'(fev_a),     32'd0);
        check_eq("a3_clr_done",    32'(done_a),    32'd0);
        check_eq("a3_busy",        32'(busy_a),    32'd1);
        repeat (8) tick();
        check_eq("a3_done", 32'(done_a), 32'd1);
        check_eq("a3_pass", 32'(pass_a), 32'd1);
        check_eq("a3_err",  32'(err_a),  32'd0);

        // Instance B: SETTLE=0, always mismatching, 2-bit counter saturates at 3
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("b_stim_e%0d", k), 32'(stim_b), 32'(k));
            check_eq($sformatf("b_smpv_e%0d", k), 32'(smpv_b), 32'd1);
            check_eq($sformatf("b_smpm_e%0d", k), 32'(smpm_b), 32'd0);
            check_eq($sformatf("b_err_e%0d", k),  32'(err_b),  32'((k < 3) ? k : 3));
            check_eq($sformatf("b_done_e%0d", k), 32'(done_b), 32'd0);
            tick();
        end
        check_eq("b_done",    32'(done_b),    32'd1);
        check_eq("b_err",     32'(err_b),     32'd3);
        check_eq("b_fev",     32'(fev_b),     32'd0);
        check_eq("b_fevalid", 32'(fevalid_b), 32'd1);
        check_eq("b_pass",    32'(pass_b),    32'd0);

        // Instance C: SETTLE=2, mismatch at vector 0, start ignored mid-sweep, then reset
        inv_c   = 1'b1;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        repeat (3) tick();
        check_eq("c_stim_e3", 32'(stim_c), 32'd1);
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check_eq("c_stim_e4", 32'(stim_c), 32'd1);
        check_eq("c_busy_e4", 32'(busy_c), 32'd1);
        repeat (2) tick();
        check_eq("c_stim_e6",    32'(stim_c),    32'd2);
        check_eq("c_err_e6",     32'(err_c),     32'd1);
        check_eq("c_fevalid_e6", 32'(fevalid_c), 32'd1);
        tick();
        reset_c = 1'b1;
        #1;
        check_eq("c_rst_stim",    32'(stim_c),    32'd0);
        check_eq("c_rst_busy",    32'(busy_c),    32'd0);
        check_eq("c_rst_err",     32'(err_c),     32'd0);
        check_eq("c_rst_fevalid", 32'(fevalid_c), 32'd0);
        check_eq("c_rst_done",    32'(done_c),    32'd0);
        check_eq("c_rst_smpv",    32'(smpv_c),    32'd0);
        tick();
        reset_c = 1'b0;
        inv_c   = 1'b0;
        tick();
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        repeat (11) tick();
        check_eq("c_done_e11", 32'(done_c), 32'd0);
        tick();
        check_eq("c_done_e12", 32'(done_c), 32'd1);
        check_eq("c_pass",     32'(pass_c), 32'd1);
        check_eq("c_err",      32'(err_c),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
